// File: rtl/if_pkg.sv
// Shared defaults and the fetch-queue entry type for the instruction-fetch stage.
package if_pkg;

  localparam int IF_ADDR_W  = 32;
  localparam int IF_DATA_W  = 32;
  localparam int IF_PC_STEP = 4;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = '0;

  // One queued fetch result: the PC it was fetched from and the instruction word.
  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO for the prefetch queue: push/pop/flush, occupancy count,
// combinational head read. Flush and reset empty the queue in one cycle.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy update; reset and flush both drop every entry.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; stale contents after a flush are unreachable, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue and valid/ready handoff to ID.
// One read per cycle to a 1-cycle-latency memory; issue is throttled by a
// credit check (queued + in flight - leaving < DEPTH) so a response always
// has a slot. A taken branch flushes the queue and drops the response that
// lands in the same cycle, which is the only one that can still be in flight.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W,
  parameter int DEPTH = 4,
  parameter int PC_STEP = IF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic [DATA_W-1:0] out_instr,
  output logic [CNT_W-1:0]  queue_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(PC_STEP - 1));

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;

  entry_t            w_head;
  entry_t            w_push_entry;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [CNT_W:0]    w_occupancy;

  // A branch cycle hides the head so ID cannot take an instruction being flushed.
  assign out_valid    = !w_empty && !branch_taken;
  assign w_pop        = out_valid && out_ready;
  assign w_push       = r_inflight && !branch_taken;
  assign w_push_entry = '{pc: r_req_pc, instr: imem_rdata};

  // Pop never exceeds the queued count, so this cannot underflow.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_pop};
  assign w_issue     = rst && !branch_taken && (w_occupancy < (CNT_W+1)'(DEPTH));

  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign out_pc      = w_head.pc;
  assign out_pc_next = w_head.pc + STEP;
  assign out_instr   = w_head.instr;
  assign queue_count = w_count;

  // Fetch PC, in-flight tag and the PC belonging to the outstanding read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (branch_taken) begin
        r_fetch_pc <= branch_address & ALIGN_MASK;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + STEP;
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  if_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .i_flush    (branch_taken),
    .o_head_data(w_head),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed timing checks plus a PC-stream
// scoreboard (sequential PCs, restarted by branches and resets) under random
// out_ready/branch stimulus. A second instance covers 8-bit address wrap.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        out_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc, out_pc_next, out_instr;
  logic [2:0]  queue_count;

  logic        s_imem_req;
  logic [7:0]  s_imem_addr;
  logic [31:0] s_imem_rdata;
  logic        s_out_valid;
  logic [7:0]  s_out_pc, s_out_pc_next;
  logic [31:0] s_out_instr;
  logic [2:0]  s_queue_count;

  int          total = 0;
  int          bad   = 0;
  int          xfers = 0;
  logic [31:0] exp_pc = 32'd0;
  logic [7:0]  s_exp  = 8'hF8;

  if_prefetch_stage dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_instr(out_instr),
    .queue_count(queue_count)
  );

  if_prefetch_stage #(.ADDR_W(8), .RESET_PC(8'hF8)) dut_s (
    .clk(clk), .rst(rst),
    .branch_taken(1'b0), .branch_address(8'h00),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_pc(s_out_pc), .out_pc_next(s_out_pc_next), .out_instr(s_out_instr),
    .queue_count(s_queue_count)
  );

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Instruction memories with a fixed one-cycle read latency.
  always @(posedge clk) begin
    imem_rdata   <= mem_of(imem_addr);
    s_imem_rdata <= mem_of({24'd0, s_imem_addr});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream model: every delivered PC continues from the last one by 4,
  // a branch restarts at the aligned target, a reset at RESET_PC.
  task automatic sb();
    if (!rst) begin
      exp_pc = 32'd0;
      s_exp  = 8'hF8;
    end else begin
      if (branch_taken) begin
        chk("br_no_valid", 32'(out_valid), 0);
        chk("br_no_req", 32'(imem_req), 0);
        exp_pc = branch_address & ~32'h3;
      end else if (out_valid && out_ready) begin
        chk("sb_pc", out_pc, exp_pc);
        chk("sb_pc_next", out_pc_next, exp_pc + 32'd4);
        chk("sb_instr", out_instr, mem_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      chk("cnt_le_depth", 32'(queue_count <= 3'd4), 1);
      if (s_out_valid) begin
        chk("s_pc", {24'd0, s_out_pc}, {24'd0, s_exp});
        chk("s_instr", s_out_instr, mem_of({24'd0, s_exp}));
        s_exp = s_exp + 8'd4;
      end
    end
  endtask

  task automatic cyc();
    #1;
    sb();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    branch_taken = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] s_want;
    rst = 1'b0;
    branch_taken = 1'b0;
    branch_address = 32'd0;
    out_ready = 1'b0;
    @(negedge clk);
    repeat (2) cyc();
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(queue_count), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_s_valid", 32'(s_out_valid), 0);

    // Streaming from reset, plus the 8-bit wrap instance.
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t1_req", 32'(imem_req), 1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk("t1_valid", 32'(out_valid), 32'(k >= 2));
      if (k >= 2) chk("t1_pc", out_pc, 32'(4 * (k - 2)));
      chk("t5_valid", 32'(s_out_valid), 32'(k >= 2));
      if (k >= 2 && k <= 5) begin
        s_want = 8'hF8 + 8'(4 * (k - 2));
        chk("t5_wrap_pc", {24'd0, s_out_pc}, {24'd0, s_want});
      end
      cyc();
    end

    // Back-pressure fills the queue, then release without gaps.
    do_reset();
    out_ready = 1'b0;
    repeat (10) cyc();
    #1;
    chk("t2_count_full", 32'(queue_count), 4);
    chk("t2_req_low", 32'(imem_req), 0);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_head_pc", out_pc, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_valid_run", 32'(out_valid), 1);
      chk("t2_pc_run", out_pc, 32'(4 * i));
      cyc();
    end

    // Branch with 3 queued and 1 in flight.
    do_reset();
    out_ready = 1'b0;
    repeat (4) cyc();
    #1;
    chk("t3_count3", 32'(queue_count), 3);
    chk("t3_credit_block", 32'(imem_req), 0);
    branch_taken = 1'b1;
    branch_address = 32'h100;
    cyc();
    branch_taken = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t3_flushed", 32'(queue_count), 0);
    chk("t3_valid0", 32'(out_valid), 0);
    chk("t3_req", 32'(imem_req), 1);
    chk("t3_addr", imem_addr, 32'h100);
    cyc();
    #1;
    chk("t3_valid1", 32'(out_valid), 0);
    cyc();
    #1;
    chk("t3_valid2", 32'(out_valid), 1);
    chk("t3_pc", out_pc, 32'h100);
    repeat (5) cyc();

    // Unaligned target, then back-to-back branches.
    branch_taken = 1'b1;
    branch_address = 32'h203;
    cyc();
    branch_taken = 1'b0;
    #1;
    chk("t4_valid0", 32'(out_valid), 0);
    cyc();
    #1;
    chk("t4_valid1", 32'(out_valid), 0);
    cyc();
    #1;
    chk("t4_pc_aligned", out_pc, 32'h200);
    repeat (4) cyc();
    branch_taken = 1'b1;
    branch_address = 32'h40;
    cyc();
    branch_address = 32'h80;
    cyc();
    branch_taken = 1'b0;
    #1;
    chk("t4_last_wins_addr", imem_addr, 32'h80);
    cyc();
    cyc();
    #1;
    chk("t4_last_wins_valid", 32'(out_valid), 1);
    chk("t4_last_wins_pc", out_pc, 32'h80);
    repeat (4) cyc();

    // Reset while full.
    out_ready = 1'b0;
    repeat (8) cyc();
    #1;
    chk("t6_full", 32'(queue_count), 4);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t6_valid0", 32'(out_valid), 0);
    chk("t6_count0", 32'(queue_count), 0);
    chk("t6_req", 32'(imem_req), 1);
    chk("t6_addr", imem_addr, 0);
    cyc();
    cyc();
    #1;
    chk("t6_restart_pc", out_pc, 0);
    chk("t6_restart_valid", 32'(out_valid), 1);
    cyc();

    // Random ready/branch traffic against the stream model.
    xfers = 0;
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 99) < 70);
      branch_taken = ($urandom_range(0, 99) < 5);
      branch_address = $urandom;
      cyc();
    end
    branch_taken = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    chk("rand_liveness", 32'(xfers > 150), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
